// File: rtl/rf_pkg.sv
// Shared types and default widths for the register-file write scheduler.
package rf_pkg;

  localparam int unsigned DefAddrWidth = 5;
  localparam int unsigned DefDataWidth = 32;

  typedef enum logic {
    StRun   = 1'b0,
    StClear = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the other
// requester after every grant and holds otherwise.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic       prio_q, prio_d;
  logic [1:0] req_eff;

  always_comb begin
    req_eff = req_i & {2{en_i}};
    gnt_o   = 2'b00;
    if (req_eff == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_eff;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt_o[0]) begin
      prio_d = 1'b1;
    end else if (gnt_o[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Merges two write requesters onto one register-file write port and runs a
// full-file zeroing sweep on demand; register 0 is never written.
module rf_write_scheduler
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  arb_en;
  logic [1:0]            gnt;

  // Grants only in RUN, out of reset, and not in the cycle a clear is requested.
  assign arb_en = rst && (state_q == StRun) && !clr_start;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (arb_en),
    .req_i ({req1_valid, req0_valid}),
    .gnt_o (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    unique case (state_q)
      StRun: begin
        if (clr_start) begin
          state_d = StClear;
          cnt_d   = ADDR_WIDTH'(1);
        end else if (gnt[0] && (req0_addr != '0)) begin
          rf_wen_d   = 1'b1;
          rf_waddr_d = req0_addr;
          rf_wdata_d = req0_data;
        end else if (gnt[1] && (req1_addr != '0)) begin
          rf_wen_d   = 1'b1;
          rf_waddr_d = req1_addr;
          rf_wdata_d = req1_data;
        end
      end
      StClear: begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = cnt_q;
        rf_wdata_d = '0;
        if (cnt_q == '1) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign clr_busy = (state_q == StClear);
  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: single write, contention, x0 drop,
// same-address ordering, full clear sweep and reset during a sweep.
module tb_rf_write_scheduler;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        clr_start;
  logic        clr_busy;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  rf_write_scheduler #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int busy_cycles;
    int stray;
    logic [1:0] exp_gnt [4];
    logic [4:0] exp_addr [4];
    exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr = '{5'd5, 5'd6, 5'd5, 5'd6};

    rst = 1'b0; clr_start = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'hFFFF_FFFF;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hFFFF_FFFF;
    tick(); tick();
    // Reset state, readies held low despite valid requests
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_wen",    32'(rf_wen),     32'd0);
    check("rst_waddr",  32'(rf_waddr),   32'd0);
    check("rst_wdata",  rf_wdata,        32'd0);
    check("rst_busy",   32'(clr_busy),   32'd0);
    check("rst_no_write_after", 32'(rf_wen), 32'd0);

    // Single requester
    rst = 1'b1; req1_valid = 1'b0;
    req0_addr = 5'd3; req0_data = 32'hDEAD_BEEF;
    #1;
    check("single_ready0", 32'(req0_ready), 32'd1);
    check("single_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    check("single_wen",   32'(rf_wen),   32'd1);
    check("single_waddr", 32'(rf_waddr), 32'd3);
    check("single_wdata", rf_wdata,      32'hDEAD_BEEF);
    tick();
    check("idle_wen",   32'(rf_wen),   32'd0);
    check("idle_waddr", 32'(rf_waddr), 32'd3);
    check("idle_wdata", rf_wdata,      32'hDEAD_BEEF);

    // Re-reset so prio starts at 0 for contention
    rst = 1'b0; tick(); rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hA0A0_0000;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'hA1A1_0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont_gnt%0d", i), 32'({req1_ready, req0_ready}), 32'(exp_gnt[i]));
      tick();
      check($sformatf("cont_wen%0d", i), 32'(rf_wen), 32'd1);
      check($sformatf("cont_waddr%0d", i), 32'(rf_waddr), 32'(exp_addr[i]));
      check($sformatf("cont_wdata%0d", i), rf_wdata,
            (exp_addr[i] == 5'd5) ? 32'hA0A0_0000 : 32'hA1A1_0001);
    end
    req0_valid = 1'b0;

    // x0 drop: handshake completes, no write, address/data hold
    req1_addr = 5'd0; req1_data = 32'h1234_5678;
    #1;
    check("x0_ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    check("x0_wen",   32'(rf_wen),   32'd0);
    check("x0_waddr", 32'(rf_waddr), 32'd6);

    // Same address from both; prio is 0 so req0 first, req1 data persists
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0111;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h0000_0222;
    #1;
    check("same_first", 32'({req1_ready, req0_ready}), 32'd1);
    tick();
    check("same_wdata0", rf_wdata, 32'h0000_0111);
    check("same_second", 32'({req1_ready, req0_ready}), 32'd2);
    tick();
    check("same_waddr", 32'(rf_waddr), 32'd7);
    check("same_wdata1", rf_wdata, 32'h0000_0222);

    // Clear coinciding with both valid; prio is 0 and must stay 0
    req0_addr = 5'd9; req0_data = 32'h0000_0055;
    req1_addr = 5'd10; req1_data = 32'h0000_0066;
    clr_start = 1'b1;
    #1;
    check("clr_start_gnt", 32'({req1_ready, req0_ready}), 32'd0);
    tick();
    clr_start = 1'b0;
    busy_cycles = 0;
    check("clr_busy0", 32'(clr_busy), 32'd1);
    check("clr_wen0",  32'(rf_wen),   32'd0);
    check("clr_gnt0",  32'({req1_ready, req0_ready}), 32'd0);
    if (clr_busy) busy_cycles++;
    for (int i = 1; i <= 31; i++) begin
      tick();
      check($sformatf("clr_wen%0d", i), 32'(rf_wen), 32'd1);
      check($sformatf("clr_waddr%0d", i), 32'(rf_waddr), 32'(i));
      check($sformatf("clr_wdata%0d", i), rf_wdata, 32'd0);
      check($sformatf("clr_gnt%0d", i), 32'({req1_ready, req0_ready}),
            (i == 31) ? 32'd1 : 32'd0);
      if (clr_busy) busy_cycles++;
    end
    check("clr_busy_cycles", 32'(busy_cycles), 32'd31);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("post_clr_wen",   32'(rf_wen),   32'd1);
    check("post_clr_waddr", 32'(rf_waddr), 32'd9);
    check("post_clr_wdata", rf_wdata,      32'h0000_0055);

    // Reset while the sweep counter is 10
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    check("mid_waddr9", 32'(rf_waddr), 32'd9);
    rst = 1'b0;
    tick();
    check("mid_busy", 32'(clr_busy), 32'd0);
    check("mid_wen",  32'(rf_wen),   32'd0);
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rf_wen || clr_busy) stray++;
    end
    check("mid_no_more_clear", 32'(stray), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_scheduler.md
RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register-file data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  each requester's write request valid.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  each requester's request accepted this cycle.
REQ-007 SHALL have ports req0_addr / req1_addr  input  ADDR_WIDTH  destination register of each requester.
REQ-008 SHALL have ports req0_data / req1_data  input  DATA_WIDTH  write data of each requester.
REQ-009 SHALL have port clr_start  input  1  single-cycle request to zero the whole register file.
REQ-010 SHALL have port clr_busy  output  1  clear sweep in progress.
REQ-011 SHALL have port rf_wen  output  1  register-file write enable, registered.
REQ-012 SHALL have port rf_waddr  output  ADDR_WIDTH  register-file write address, registered.
REQ-013 SHALL have port rf_wdata  output  DATA_WIDTH  register-file write data, registered.

Function
REQ-014 SHALL implement a two-state FSM with states RUN and CLEAR.
REQ-015 A transfer on requester k SHALL occur when reqk_valid and reqk_ready are both 1 in the same cycle.
REQ-016 In RUN with clr_start=0, readies SHALL be combinational:
- only one valid -> grant it;
- both valid -> grant the requester named by priority pointer prio;
- neither valid -> no grant.
- At most one ready SHALL be 1 per cycle.
REQ-017 After any grant to requester k, prio SHALL become the other requester. With no grant, prio SHALL hold.
REQ-018 An accepted transfer SHALL appear on rf_wen/rf_waddr/rf_wdata exactly one cycle later (latency 1), with sustained throughput of one write per cycle.
REQ-019 An accepted transfer with addr = 0 SHALL complete the handshake but SHALL NOT assert rf_wen; register 0 is hardwired zero.
REQ-020 In any cycle with no accepted write and no clear write, rf_wen SHALL be 0. rf_waddr and rf_wdata SHALL hold their previous values.
REQ-021 clr_start=1 in RUN SHALL force both readies to 0 in that cycle and move the FSM to CLEAR, with sweep counter cnt=1.
REQ-022 In CLEAR:
- both readies SHALL be 0;
- each cycle SHALL issue rf_wen=1, rf_waddr=cnt, rf_wdata=0 on the following cycle, then increment cnt.
REQ-023 When cnt equals all-ones, that write SHALL be issued and the FSM SHALL return to RUN. The counter SHALL never wrap, giving exactly 2**ADDR_WIDTH-1 clear writes.
REQ-024 clr_busy SHALL equal (state == CLEAR). clr_start SHALL be ignored while in CLEAR.
REQ-025 Writes granted in the first RUN cycle after CLEAR SHALL reach the register file after the last clear write, never before it.
REQ-026 Both requesters targeting the same address SHALL be serialized by arbitration. The later grant's data SHALL persist.

Reset
REQ-027 While rst=0 at posedge clk, the block SHALL set:
- state to RUN, prio to 0, cnt to 0;
- rf_wen, rf_waddr, rf_wdata to 0;
- clr_busy to 0.
REQ-028 While rst=0, both readies SHALL be 0.
REQ-029 Reset asserted mid-CLEAR SHALL abort the sweep with no further clear writes.

Structure
REQ-030 The FSM state type, and the RUN/CLEAR encodings, SHALL be declared in shared package rf_pkg, alongside the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-031 Arbitration SHALL live in one sub-module, rr_arbiter2: two requests in, one-hot grant out, internal prio register, same clk/rst.
REQ-032 Total RTL SHALL be 120-400 lines. The block SHALL contain no storage of register contents.

Verification
REQ-033 Single requester: req0 valid, addr=3, data=0xDEADBEEF -> req0_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=3, rf_wdata=0xDEADBEEF.
REQ-034 Contention: both valid for 4 cycles, prio=0 after reset -> grants 0,1,0,1; rf writes follow in that order, one per cycle.
REQ-035 x0 drop: req1 addr=0, data=0x12345678 -> req1_ready=1; next cycle rf_wen=0.
REQ-036 Clear: pulse clr_start with ADDR_WIDTH=5 -> clr_busy=1 for 31 cycles; rf_wen=1 with waddr 1..31 and wdata=0 on consecutive cycles; readies 0 throughout; req0 held valid is granted on the first RUN cycle.
REQ-037 Reset mid-clear: drive rst=0 when cnt=10 -> next cycle clr_busy=0 and rf_wen=0; no write to address 11 ever appears.
REQ-038 clr_start coinciding with both requesters valid -> no grant that cycle; prio unchanged; clear proceeds normally.
